// File: rtl/hilo_div_pkg.sv
// Shared types and constants for the HI/LO divide controller and its core.
package hilo_div_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    FIX    = 2'd3
  } state_t;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam int          DIV_ITERS  = 32;

endpackage

// File: rtl/hilo_div_if.sv
// Execute-stage <-> divide controller bus: divide requests, MTHI/MTLO writes, HI/LO results.
interface hilo_div_if
  import hilo_div_pkg::*;
#(
  parameter int WIDTH = DIV_ITERS
) ();

  logic             op_valid;
  logic             op_signed;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_ready;
  logic             stall;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             done;
  logic             div_zero;

  modport master (
    output op_valid, op_signed, op_a, op_b, wr_hi, wr_lo, wr_data,
    input  op_ready, stall, hi, lo, done, div_zero
  );

  modport slave (
    input  op_valid, op_signed, op_a, op_b, wr_hi, wr_lo, wr_data,
    output op_ready, stall, hi, lo, done, div_zero
  );

endinterface

// File: rtl/hilo_div_ctrl_divu_core.sv
// Iterative unsigned non-restoring divider: one quotient bit per falling edge, start/busy handshake.
module divu_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = '0;
    if (busy_q) begin
      // Partial remainder stays in [-d, d); its sign picks add vs subtract next step.
      trial  = rem_q[WIDTH] ? shifted + {2'b00, div_q} : shifted - {2'b00, div_q};
      rem_d  = trial[WIDTH:0];
      quo_d  = {quo_q[WIDTH-2:0], ~trial[WIDTH+1]};
      cnt_d  = cnt_q - 1'b1;
      busy_d = (cnt_q != CW'(1));
    end else if (start) begin
      rem_d  = '0;
      quo_d  = dividend;
      div_d  = divisor;
      cnt_d  = CW'(WIDTH);
      busy_d = 1'b1;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign quotient  = quo_q;
  assign remainder = rem_q[WIDTH] ? rem_q[WIDTH-1:0] + div_q : rem_q[WIDTH-1:0];

endmodule

// File: rtl/hilo_div_ctrl.sv
// DIV/DIVU sequencer: operand magnitudes, core launch, sign fix-up, HI/LO commit, MTHI/MTLO.
module hilo_div_ctrl
  import hilo_div_pkg::*;
#(
  parameter int WIDTH = DIV_ITERS
) (
  input  logic       clock,
  input  logic       reset_n,
  hilo_div_if.slave  bus
);

  state_t           state_q, state_d;
  logic             signed_q, signed_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] mag_a_q, mag_a_d;
  logic [WIDTH-1:0] mag_b_q, mag_b_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;
  logic             op_ready_q, op_ready_d;
  logic             stall_q, stall_d;

  logic             core_rst;
  logic             core_start;
  logic             core_busy;
  logic [WIDTH-1:0] core_q;
  logic [WIDTH-1:0] core_r;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign core_rst   = ~reset_n;
  assign core_start = (state_q == LAUNCH);

  divu_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clock),
    .rst       (core_rst),
    .start     (core_start),
    .dividend  (mag_a_q),
    .divisor   (mag_b_q),
    .busy      (core_busy),
    .quotient  (core_q),
    .remainder (core_r)
  );

  // Remainder takes the dividend's sign, so MIN/-1 wraps to MIN with zero remainder.
  assign quo_fix = (signed_q && (sign_a_q ^ sign_b_q)) ? -core_q : core_q;
  assign rem_fix = (signed_q && sign_a_q) ? -core_r : core_r;

  always_comb begin
    state_d    = state_q;
    signed_d   = signed_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    dz_d       = dz_q;
    mag_a_d    = mag_a_q;
    mag_b_d    = mag_b_q;
    a_raw_d    = a_raw_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    case (state_q)
      IDLE: begin
        if (bus.wr_hi) hi_d = bus.wr_data;
        if (bus.wr_lo) lo_d = bus.wr_data;
        if (bus.op_valid) begin
          signed_d   = bus.op_signed;
          sign_a_d   = bus.op_signed & bus.op_a[WIDTH-1];
          sign_b_d   = bus.op_signed & bus.op_b[WIDTH-1];
          mag_a_d    = sign_a_d ? -bus.op_a : bus.op_a;
          mag_b_d    = sign_b_d ? -bus.op_b : bus.op_b;
          a_raw_d    = bus.op_a;
          dz_d       = (bus.op_b == '0);
          div_zero_d = 1'b0;
          state_d    = dz_d ? FIX : LAUNCH;
        end
      end
      LAUNCH: state_d = RUN;
      RUN: if (!core_busy) state_d = FIX;
      FIX: begin
        if (dz_q) begin
          lo_d       = WIDTH'(DIV_ZERO_Q);
          hi_d       = a_raw_q;
          div_zero_d = 1'b1;
        end else begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    op_ready_d = (state_d == IDLE);
    stall_d    = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      signed_q   <= 1'b0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      dz_q       <= 1'b0;
      mag_a_q    <= '0;
      mag_b_q    <= '0;
      a_raw_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      op_ready_q <= 1'b1;
      stall_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      signed_q   <= signed_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      dz_q       <= dz_d;
      mag_a_q    <= mag_a_d;
      mag_b_q    <= mag_b_d;
      a_raw_q    <= a_raw_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      op_ready_q <= op_ready_d;
      stall_q    <= stall_d;
    end
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.op_ready = op_ready_q;
  assign bus.stall    = stall_q;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Directed bench for hilo_div_ctrl: vector table of divides plus MTHI/MTLO and reset-abort sequences.
module tb_hilo_div_ctrl;

  logic clock;
  logic reset_n;
  int   total;
  int   bad;

  hilo_div_if #(.WIDTH(32)) bus ();

  hilo_div_ctrl #(.WIDTH(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    bit          dz;
    int          lat;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic start_op(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.op_valid  = 1'b1;
    bus.op_signed = sgn;
    bus.op_a      = a;
    bus.op_b      = b;
    @(posedge clock);
    #1;
    bus.op_valid = 1'b0;
  endtask

  // Counts rising edges until done; stall must hold and op_ready stay low until then.
  task automatic wait_done(output int lat, output bit stall_ok);
    lat      = -1;
    stall_ok = bus.stall && !bus.op_ready;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clock);
      #1;
      if (bus.done) begin
        lat = k;
        break;
      end
      if (!bus.stall || bus.op_ready) stall_ok = 1'b0;
    end
  endtask

  task automatic run_op(input string nm, input vec_t v);
    int lat;
    bit stall_ok;
    start_op(v.sgn, v.a, v.b);
    wait_done(lat, stall_ok);
    $display("op %s: sgn=%0d a=%h b=%h -> lo=%h hi=%h dz=%0d lat=%0d", nm, v.sgn, v.a, v.b,
             bus.lo, bus.hi, bus.div_zero, lat);
    check({nm, " latency"}, lat, v.lat);
    check({nm, " lo"}, bus.lo, v.lo);
    check({nm, " hi"}, bus.hi, v.hi);
    check({nm, " div_zero"}, {31'b0, bus.div_zero}, {31'b0, v.dz});
    check({nm, " stall"}, {31'b0, stall_ok}, 32'd1);
    check({nm, " op_ready"}, {31'b0, bus.op_ready}, 32'd1);
    @(posedge clock);
    #1;
    check({nm, " done pulse"}, {31'b0, bus.done}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int  lat;
    bit  stall_ok;
    bit  seen_done;
    vec_t v;

    total = 0;
    bad   = 0;
    vecs[0]  = '{0, 32'd100,        32'd7,          32'd14,         32'd2,          0, 34};
    vecs[1]  = '{1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  0, 34};
    vecs[2]  = '{1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          0, 34};
    vecs[3]  = '{0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1, 1};
    vecs[4]  = '{0, 32'd9,          32'd3,          32'd3,          32'd0,          0, 34};
    vecs[5]  = '{1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          0, 34};
    vecs[6]  = '{1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  0, 34};
    vecs[7]  = '{0, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  32'd1,          0, 34};
    vecs[8]  = '{1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1, 1};
    vecs[9]  = '{0, 32'd3,          32'd10,         32'd0,          32'd3,          0, 34};
    vecs[10] = '{0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          0, 34};
    vecs[11] = '{0, 32'd1000,       32'd3,          32'd333,        32'd1,          0, 34};

    reset_n       = 1'b0;
    bus.op_valid  = 1'b0;
    bus.op_signed = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.wr_hi     = 1'b0;
    bus.wr_lo     = 1'b0;
    bus.wr_data   = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    $display("reset: hi=%h lo=%h done=%0d dz=%0d ready=%0d stall=%0d", bus.hi, bus.lo, bus.done,
             bus.div_zero, bus.op_ready, bus.stall);
    check("reset hi", bus.hi, 32'd0);
    check("reset lo", bus.lo, 32'd0);
    check("reset done", {31'b0, bus.done}, 32'd0);
    check("reset div_zero", {31'b0, bus.div_zero}, 32'd0);
    check("reset op_ready", {31'b0, bus.op_ready}, 32'd1);
    check("reset stall", {31'b0, bus.stall}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      v = vecs[i];
      run_op($sformatf("vec%0d", i), v);
    end

    // MTHI and a second op_valid while the core is running must both be dropped.
    start_op(1'b0, 32'd100, 32'd7);
    repeat (5) @(posedge clock);
    @(negedge clock);
    bus.wr_hi     = 1'b1;
    bus.wr_data   = 32'h1234;
    bus.op_valid  = 1'b1;
    bus.op_a      = 32'd50;
    bus.op_b      = 32'd5;
    @(negedge clock);
    bus.wr_hi    = 1'b0;
    bus.op_valid = 1'b0;
    wait_done(lat, stall_ok);
    $display("mthi in RUN: hi=%h lo=%h", bus.hi, bus.lo);
    check("mthi ignored hi", bus.hi, 32'd2);
    check("mthi ignored lo", bus.lo, 32'd14);
    check("mthi stall", {31'b0, stall_ok}, 32'd1);
    seen_done = 1'b0;
    repeat (4) begin
      @(posedge clock);
      #1;
      if (bus.done || !bus.op_ready) seen_done = 1'b1;
    end
    check("op_valid in RUN not queued", {31'b0, seen_done}, 32'd0);

    @(negedge clock);
    bus.wr_lo   = 1'b1;
    bus.wr_data = 32'hABCD;
    @(posedge clock);
    #1;
    bus.wr_lo = 1'b0;
    $display("mtlo in IDLE: hi=%h lo=%h", bus.hi, bus.lo);
    check("mtlo lo", bus.lo, 32'hABCD);
    check("mtlo hi kept", bus.hi, 32'd2);

    // Reset partway through a divide: state and HI/LO cleared, no done afterwards.
    start_op(1'b0, 32'd1000, 32'd3);
    repeat (9) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    $display("reset mid-op: hi=%h lo=%h ready=%0d stall=%0d done=%0d", bus.hi, bus.lo,
             bus.op_ready, bus.stall, bus.done);
    check("abort hi", bus.hi, 32'd0);
    check("abort lo", bus.lo, 32'd0);
    check("abort op_ready", {31'b0, bus.op_ready}, 32'd1);
    check("abort stall", {31'b0, bus.stall}, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n   = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (bus.done) seen_done = 1'b1;
    end
    check("abort no done", {31'b0, seen_done}, 32'd0);
    check("abort still idle", {31'b0, bus.op_ready}, 32'd1);
    v = vecs[11];
    run_op("after abort", v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hilo_div_ctrl.md
# hilo_div_ctrl

Sequencing controller between the execute stage and the iterative unsigned divider core. Accepts signed (DIV) and unsigned (DIVU) divide requests, converts signed operands to magnitudes, drives the core's start/busy handshake, applies sign correction, and commits quotient/remainder into the architectural LO/HI registers. It also services MTHI/MTLO writes and raises a pipeline stall while a divide is in flight.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; the core iterates `WIDTH` times.

Ports:
- `clock` in 1: single clock. The controller uses the rising edge; the core sub-module uses the falling edge.
- `reset_n` in 1: asynchronous, active-low reset. The core receives `~reset_n`.
- `op_valid` in 1: divide request.
- `op_signed` in 1: 1 = DIV, 0 = DIVU.
- `op_a` in WIDTH: dividend.
- `op_b` in WIDTH: divisor.
- `op_ready` out 1: high only in IDLE.
- `stall` out 1: high whenever state ≠ IDLE.
- `wr_hi` in 1: MTHI write enable.
- `wr_lo` in 1: MTLO write enable.
- `wr_data` in WIDTH: MTHI/MTLO data.
- `hi` out WIDTH: HI register (remainder).
- `lo` out WIDTH: LO register (quotient).
- `done` out 1: one-cycle pulse on HI/LO commit.
- `div_zero` out 1: sticky flag; cleared on the next accepted op.

## Operation
- Reset: state IDLE; `hi`/`lo` = 0; `done` = 0; `div_zero` = 0; `op_ready` = 1; `stall` = 0.
- States and transitions:
  - IDLE: on `op_valid`, latch signs, magnitudes and `op_a`. Go to FIX if `op_b` = 0, else to LAUNCH.
  - LAUNCH: `core_start` = 1 (combinational from state). Go to RUN unconditionally; the core has raised busy at the intervening falling edge.
  - RUN: wait until `core_busy` = 0, then go to FIX.
  - FIX: register HI/LO, pulse `done`, return to IDLE.
- Magnitudes:
  - For signed ops, a negative operand is replaced by its two's complement.
  - For unsigned ops, operands pass through unchanged.
- Sign correction in FIX:
  - Quotient is negated if sign_a XOR sign_b.
  - Remainder is negated if sign_a.
  - Sign correction applies only when `op_signed` is set.
- Overflow: 0x80000000 / 0xFFFFFFFF (signed) gives LO = 0x80000000, HI = 0. No trap.
- Divide by zero: no core launch. LO = 0xFFFFFFFF, HI = `op_a`, `div_zero` = 1.
- MTHI/MTLO:
  - Honoured only in IDLE; ignored in every other state.
  - If a write and an op acceptance occur in the same IDLE cycle, the write is applied and is later overwritten by the result.
- `op_valid` is ignored outside IDLE; there is no queuing.

## Timing
- Acceptance at rising edge 0. For a nonzero divisor, HI/LO update and `done` rise at rising edge 34. `op_ready` returns high in the same cycle as `done`.
- Cycle breakdown:
  - LAUNCH covers edge 0 to edge 1.
  - The core performs 32 iterations on falling edges 1.5 through 32.5.
  - RUN observes busy low at edge 33.
  - FIX commits at edge 34.
- Divide by zero: commit and `done` at edge 1.
- `stall` is high from edge 0 through the cycle before the commit edge.
- Reset asserted mid-operation:
  - Immediate return to IDLE.
  - Core aborted.
  - HI/LO cleared.
  - No `done` pulse.

## Structure
- Shared package holds:
  - the state enum {IDLE, LAUNCH, RUN, FIX};
  - the constant `DIV_ZERO_Q` = all ones;
  - the constant `DIV_ITERS` = 32.
- One sub-module: `divu_core`, the existing 32-iteration unsigned non-restoring divider with start/busy/q/r, falling-edge, active-high reset. It is instantiated once.
- Magnitude and sign-fix logic stays inline.

## Test plan
- DIVU 100 / 7 → at edge 34: LO = 14, HI = 2, `done` one cycle, `stall` high for edges 0–33.
- DIV 0xFFFFFFF9 (−7) / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0, `div_zero` = 0.
- DIVU 5 / 0 → at edge 1: LO = 0xFFFFFFFF, HI = 5, `div_zero` = 1. The next DIVU 9 / 3 clears `div_zero` and gives LO = 3, HI = 0.
- MTHI 0x1234 issued in RUN → ignored, HI = result. MTLO 0xABCD in IDLE → LO = 0xABCD next cycle.
- `reset_n` low at cycle 10 of DIVU 1000 / 3 → HI = LO = 0, IDLE, no `done`. A subsequent DIVU 1000 / 3 gives LO = 333, HI = 1 at edge 34.
